// File: rtl/vram_write_arbiter_if.sv
// Framebuffer write-arbiter bus: splash burst port, game pixel port, status and RAM write port.
// The master drives the requester inputs; the slave is the arbiter.
interface vram_write_arbiter_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int ADDR_W  = 15,
  parameter int COLOR_W = 3
);
  logic               spl_req;
  logic [X_W-1:0]     spl_x;
  logic [Y_W-1:0]     spl_y;
  logic [COLOR_W-1:0] spl_color;
  logic               spl_last;
  logic               spl_gnt;
  logic               game_valid;
  logic [X_W-1:0]     game_x;
  logic [Y_W-1:0]     game_y;
  logic [COLOR_W-1:0] game_color;
  logic               game_ready;
  logic               busy;
  logic               oob_err;
  logic               vram_wren;
  logic [ADDR_W-1:0]  vram_addr;
  logic [COLOR_W-1:0] vram_data;

  modport master (
    output spl_req, spl_x, spl_y, spl_color, spl_last,
    output game_valid, game_x, game_y, game_color,
    input  spl_gnt, game_ready, busy, oob_err,
    input  vram_wren, vram_addr, vram_data
  );

  modport slave (
    input  spl_req, spl_x, spl_y, spl_color, spl_last,
    input  game_valid, game_x, game_y, game_color,
    output spl_gnt, game_ready, busy, oob_err,
    output vram_wren, vram_addr, vram_data
  );
endinterface

// File: rtl/vram_write_arbiter.sv
// Shares the framebuffer write port between atomic splash fill bursts (priority)
// and FIFO-buffered single-pixel game writes; emits registered wren/addr/data.
module vram_write_arbiter #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int ADDR_W     = 15,
  parameter int COLOR_W    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  vram_write_arbiter_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int PIX_W = X_W + Y_W + COLOR_W;

  typedef enum logic [1:0] {IDLE, SPLASH, GAME} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [COLOR_W-1:0] data_q;
  logic              oob_q;
  logic [PIX_W-1:0]  mem_q [FIFO_DEPTH];

  logic               fifo_full, fifo_empty;
  logic               push, pop, gnt, consume, in_range;
  logic [PIX_W-1:0]   pix;
  logic [X_W-1:0]     px_x;
  logic [Y_W-1:0]     px_y;
  logic [COLOR_W-1:0] px_c;
  logic [ADDR_W-1:0]  lin_addr;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Readiness looks only at the registered count, never at a same-cycle pop.
  assign bus.game_ready = !rst && !fifo_full;
  assign push = bus.game_valid && !fifo_full;
  assign gnt  = (state_q == SPLASH) && bus.spl_req;
  assign pop  = (state_q == GAME) && !fifo_empty;
  assign consume = gnt || pop;

  assign pix = gnt ? {bus.spl_x, bus.spl_y, bus.spl_color} : mem_q[rd_ptr_q];
  assign {px_x, px_y, px_c} = pix;
  assign in_range = (32'(px_x) < 32'(WIDTH)) && (32'(px_y) < 32'(HEIGHT));
  assign lin_addr = ADDR_W'(px_y) * ADDR_W'(WIDTH) + ADDR_W'(px_x);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.spl_req)   state_d = SPLASH;
        else if (!fifo_empty) state_d = GAME;
      end
      SPLASH: begin
        if (!bus.spl_req)      state_d = IDLE;
        else if (bus.spl_last) state_d = (count_d != '0) ? GAME : IDLE;
      end
      GAME: begin
        if (bus.spl_req)          state_d = SPLASH;
        else if (count_d == '0)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      oob_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      wren_q <= consume && in_range;
      if (consume && in_range) begin
        addr_q <= lin_addr;
        data_q <= px_c;
      end
      if (consume && !in_range) oob_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.game_x, bus.game_y, bus.game_color};
  end

  assign bus.spl_gnt   = gnt;
  assign bus.busy      = (state_q != IDLE) || !fifo_empty;
  assign bus.oob_err   = oob_q;
  assign bus.vram_wren = wren_q;
  assign bus.vram_addr = addr_q;
  assign bus.vram_data = data_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Randomized and directed bench for vram_write_arbiter against a queue-based
// transaction model of the arbitration and write rules.
module tb_vram_write_arbiter;

  localparam int WIDTH = 160, HEIGHT = 120, X_W = 8, Y_W = 7;
  localparam int ADDR_W = 15, COLOR_W = 3, DEPTH = 4;
  localparam int M_IDLE = 0, M_SPL = 1, M_GAME = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_write_arbiter_if #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) bus ();

  vram_write_arbiter #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .X_W(X_W), .Y_W(Y_W),
    .ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct { int x; int y; int c; } pix_t;

  int   vectors = 0;
  int   fails   = 0;
  pix_t mq[$];
  int   m_mode;
  bit   m_wren, m_oob;
  int   m_addr, m_data;
  bit   m_ready, m_gnt, m_push, m_pop, m_busy;
  logic [22:0] exp_v, obs_v;
  int   wlog[$];

  function automatic void model_reset();
    mq.delete();
    m_mode = M_IDLE;
    m_wren = 0; m_addr = 0; m_data = 0; m_oob = 0;
  endfunction

  function automatic void model_update();
    int   n0;
    bit   consumed;
    pix_t p;
    n0 = mq.size();
    consumed = 0;
    p = '{x: 0, y: 0, c: 0};
    if (m_gnt) begin
      consumed = 1;
      p = '{x: int'(bus.spl_x), y: int'(bus.spl_y), c: int'(bus.spl_color)};
    end else if (m_pop) begin
      consumed = 1;
      p = mq.pop_front();
    end
    if (m_push) mq.push_back('{x: int'(bus.game_x), y: int'(bus.game_y), c: int'(bus.game_color)});
    m_wren = 0;
    if (consumed) begin
      if (p.x < WIDTH && p.y < HEIGHT) begin
        m_wren = 1; m_addr = p.y * WIDTH + p.x; m_data = p.c;
      end else m_oob = 1;
    end
    case (m_mode)
      M_IDLE: m_mode = bus.spl_req ? M_SPL : (n0 != 0 ? M_GAME : M_IDLE);
      M_SPL: begin
        if (!bus.spl_req) m_mode = M_IDLE;
        else if (bus.spl_last) m_mode = (mq.size() != 0) ? M_GAME : M_IDLE;
      end
      default: begin
        if (bus.spl_req) m_mode = M_SPL;
        else if (mq.size() == 0) m_mode = M_IDLE;
      end
    endcase
  endfunction

  // One clock: sample DUT and model at negedge, advance the model at posedge.
  task automatic tick();
    @(negedge clk);
    if (rst) model_reset();
    m_ready = !rst && (mq.size() < DEPTH);
    m_gnt   = (m_mode == M_SPL) && bus.spl_req;
    m_pop   = (m_mode == M_GAME) && (mq.size() > 0);
    m_push  = bus.game_valid && m_ready;
    m_busy  = (m_mode != M_IDLE) || (mq.size() != 0);
    exp_v = {m_wren, 15'(m_addr), 3'(m_data), m_gnt, m_ready, m_busy, m_oob};
    obs_v = {bus.vram_wren, bus.vram_addr, bus.vram_data, bus.spl_gnt,
             bus.game_ready, bus.busy, bus.oob_err};
    if (bus.vram_wren) wlog.push_back(int'(bus.vram_addr));
    @(posedge clk);
    if (!rst) model_update();
    #1;
  endtask

  task automatic drive_idle();
    bus.spl_req = 0; bus.spl_x = '0; bus.spl_y = '0; bus.spl_color = '0; bus.spl_last = 0;
    bus.game_valid = 0; bus.game_x = '0; bus.game_y = '0; bus.game_color = '0;
  endtask

  task automatic set_spl(input int x, input int y, input bit last);
    bus.spl_x = 8'(x); bus.spl_y = 7'(y); bus.spl_last = last;
    bus.spl_color = 3'($urandom_range(0, 7));
  endtask

  task automatic test_reset();
    rst = 1; drive_idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      if (obs_v !== 23'd0) begin fails++; $display("FAIL reset_state: got %h expected %h", obs_v, 23'd0); end
      vectors++;
    end
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (obs_v !== exp_v) begin fails++; $display("FAIL reset_release: got %h expected %h", obs_v, exp_v); end
      vectors++;
    end
  endtask

  task automatic test_game_single();
    int first = -1;
    logic [14:0] fa = '0;
    logic [2:0]  fd = '0;
    drive_idle(); wlog.delete();
    bus.game_valid = 1; bus.game_x = 8'd10; bus.game_y = 7'd5; bus.game_color = 3'd3;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (obs_v !== exp_v) begin fails++; $display("FAIL game_single cyc %0d: got %h expected %h", k, obs_v, exp_v); end
      vectors++;
      if (obs_v[22] && first < 0) begin first = k; fa = obs_v[21:7]; fd = obs_v[6:4]; end
      bus.game_valid = 0;
    end
    if (first !== 3 || fa !== 15'd810 || fd !== 3'd3) begin
      fails++; $display("FAIL game_single_write: got cyc %0d addr %0d data %0d expected cyc 3 addr 810 data 3", first, fa, fd);
    end
    vectors++;
  endtask

  task automatic test_splash_fill();
    int x = 0, y = 0, first_gnt = -1, bad = -1;
    bit done = 0;
    drive_idle(); wlog.delete();
    bus.spl_req = 1; set_spl(0, 0, 0);
    for (int k = 0; k < 19300 && !done; k++) begin
      tick();
      if (obs_v !== exp_v) begin fails++; $display("FAIL fill cyc %0d: got %h expected %h", k, obs_v, exp_v); end
      vectors++;
      if (obs_v[3] && first_gnt < 0) first_gnt = k;
      if (m_gnt) begin
        if (x == WIDTH - 1 && y == HEIGHT - 1) begin done = 1; bus.spl_req = 0; bus.spl_last = 0; end
        else begin
          if (x == WIDTH - 1) begin x = 0; y++; end else x++;
          set_spl(x, y, (x == WIDTH - 1 && y == HEIGHT - 1));
        end
      end
    end
    if (!done) begin fails++; $display("FAIL fill_timeout: got incomplete burst expected 19200 grants"); end
    vectors++;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (obs_v !== exp_v) begin fails++; $display("FAIL fill_tail cyc %0d: got %h expected %h", k, obs_v, exp_v); end
      vectors++;
    end
    for (int i = 0; i < wlog.size(); i++) if (wlog[i] != i && bad < 0) bad = i;
    if (wlog.size() != 19200 || bad >= 0 || first_gnt != 1) begin
      fails++; $display("FAIL fill_order: got %0d writes first_bad %0d first_gnt %0d expected 19200 writes in order first_gnt 1", wlog.size(), bad, first_gnt);
    end
    vectors++;
    if (obs_v[1] !== 1'b0) begin fails++; $display("FAIL fill_idle: got busy %b expected 0", obs_v[1]); end
    vectors++;
  endtask

  task automatic test_contention();
    int sidx = 0, pushes = 0;
    bit saw_full = 0;
    int exp_log[$];
    drive_idle(); wlog.delete();
    for (int i = 0; i < 20; i++) exp_log.push_back(50 * WIDTH + i);
    for (int i = 0; i < 6; i++) exp_log.push_back(7 * WIDTH + i * 3 + 1);
    bus.spl_req = 1; set_spl(0, 50, 0);
    for (int k = 0; k < 60; k++) begin
      bus.game_valid = (pushes < 6);
      bus.game_x = 8'(pushes * 3 + 1); bus.game_y = 7'd7; bus.game_color = 3'(pushes);
      tick();
      if (obs_v !== exp_v) begin fails++; $display("FAIL contention cyc %0d: got %h expected %h", k, obs_v, exp_v); end
      vectors++;
      if (!obs_v[2] && bus.game_valid) saw_full = 1;
      if (m_push) pushes++;
      if (m_gnt) begin
        sidx++;
        if (sidx == 20) begin bus.spl_req = 0; bus.spl_last = 0; end
        else set_spl(sidx, 50, sidx == 19);
      end
    end
    if (wlog != exp_log || !saw_full) begin
      fails++; $display("FAIL contention_order: got %0d writes full_seen %b expected 26 writes splash-then-fifo full_seen 1", wlog.size(), saw_full);
    end
    vectors++;
  endtask

  task automatic test_preempt();
    int sidx = 0, b = 0, pushes = 0;
    int exp_log[$];
    drive_idle(); wlog.delete();
    exp_log = '{1600, 1601, 1602, 1603, 1604, 1, 3200, 3201, 3202, 3203, 3204, 2, 3};
    bus.spl_req = 1; set_spl(0, 10, 0);
    for (int k = 0; k < 30; k++) begin
      bus.game_valid = (pushes < 3);
      bus.game_x = 8'(pushes + 1); bus.game_y = '0; bus.game_color = 3'd6;
      tick();
      if (obs_v !== exp_v) begin fails++; $display("FAIL preempt cyc %0d: got %h expected %h", k, obs_v, exp_v); end
      vectors++;
      if (m_push) pushes++;
      if (m_gnt) begin
        sidx++;
        if (sidx == 5) begin sidx = 0; b++; end
        if (b == 2) begin bus.spl_req = 0; bus.spl_last = 0; end
        else set_spl(sidx, (b == 0) ? 10 : 20, sidx == 4);
      end
    end
    if (wlog != exp_log) begin
      fails++; $display("FAIL preempt_order: got %0d writes expected 13 (1 pop, burst, 2 pops)", wlog.size());
    end
    vectors++;
  endtask

  task automatic test_oob();
    drive_idle(); wlog.delete();
    bus.game_valid = 1; bus.game_x = 8'd160; bus.game_y = '0; bus.game_color = 3'd5;
    for (int k = 0; k < 14; k++) begin
      if (k == 5) begin bus.spl_req = 1; bus.spl_x = '0; bus.spl_y = 7'd120; bus.spl_last = 1; end
      tick();
      if (obs_v !== exp_v) begin fails++; $display("FAIL oob cyc %0d: got %h expected %h", k, obs_v, exp_v); end
      vectors++;
      bus.game_valid = 0;
      if (m_gnt) begin bus.spl_req = 0; bus.spl_last = 0; end
    end
    if (wlog.size() != 0 || obs_v[0] !== 1'b1) begin
      fails++; $display("FAIL oob_sticky: got writes %0d oob %b expected writes 0 oob 1", wlog.size(), obs_v[0]);
    end
    vectors++;
    rst = 1;
    tick();
    if (obs_v[0] !== 1'b0) begin fails++; $display("FAIL oob_clear: got %b expected 0", obs_v[0]); end
    vectors++;
    rst = 0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int x = 0, grants = 0;
    drive_idle(); wlog.delete();
    bus.spl_req = 1; set_spl(0, 0, 0);
    for (int k = 0; k < 100 && grants < 49; k++) begin
      tick();
      if (obs_v !== exp_v) begin fails++; $display("FAIL midrst_burst cyc %0d: got %h expected %h", k, obs_v, exp_v); end
      vectors++;
      if (m_gnt) begin grants++; x++; set_spl(x, 0, 0); end
    end
    if (grants != 49) begin fails++; $display("FAIL midrst_timeout: got %0d grants expected 49", grants); end
    vectors++;
    rst = 1; bus.spl_req = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (obs_v[22] !== 1'b0 || obs_v[2] !== 1'b0) begin
        fails++; $display("FAIL midrst_hold: got wren %b ready %b expected 0 0", obs_v[22], obs_v[2]);
      end
      vectors++;
    end
    rst = 0; wlog.delete();
    for (int k = 0; k < 5; k++) begin
      tick();
      if (obs_v !== exp_v) begin fails++; $display("FAIL midrst_after cyc %0d: got %h expected %h", k, obs_v, exp_v); end
      vectors++;
    end
    if (wlog.size() != 0 || obs_v[1] !== 1'b0) begin
      fails++; $display("FAIL midrst_quiet: got writes %0d busy %b expected 0 0", wlog.size(), obs_v[1]);
    end
    vectors++;
  endtask

  task automatic test_random();
    bit sp_active = 0;
    int sx = 0, sy = 0, sp_left = 0;
    drive_idle();
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (obs_v !== exp_v) begin fails++; $display("FAIL random cyc %0d: got %h expected %h", k, obs_v, exp_v); end
      vectors++;
      if (rst) rst = 0;
      else if ($urandom_range(0, 999) == 0) begin rst = 1; sp_active = 0; end
      if (sp_active) begin
        if (m_gnt) begin
          sp_left--;
          if (sp_left == 0) sp_active = 0;
          else begin sx = (sx >= 170) ? 0 : sx + 1; end
        end else if ($urandom_range(0, 39) == 0) sp_active = 0;
      end else if (!rst && $urandom_range(0, 39) == 0) begin
        sp_active = 1; sp_left = $urandom_range(1, 12);
        sx = $urandom_range(0, 165); sy = $urandom_range(0, 123);
      end
      bus.spl_req = sp_active;
      if (sp_active) set_spl(sx, sy, sp_left == 1);
      else bus.spl_last = 0;
      if (m_push || !bus.game_valid) begin
        bus.game_valid = 1'($urandom_range(0, 1));
        bus.game_x = 8'($urandom_range(0, 163));
        bus.game_y = 7'($urandom_range(0, 121));
        bus.game_color = 3'($urandom_range(0, 7));
      end
    end
    rst = 0; drive_idle();
    for (int k = 0; k < 10; k++) begin
      tick();
      if (obs_v !== exp_v) begin fails++; $display("FAIL random_drain cyc %0d: got %h expected %h", k, obs_v, exp_v); end
      vectors++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_game_single();
    test_splash_fill();
    test_contention();
    test_preempt();
    test_oob();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/vram_write_arbiter.md
Name: vram_write_arbiter

Overview:
- Owns the single VGA framebuffer write port and shares it between two requesters.
- Requester S is the splash/title sequencer. It issues full-screen fill bursts of title, black, game-over or red.
- Requester G is the snake game renderer. It issues sparse single-pixel writes for head, tail and food.
- Splash bursts are atomic and take priority. Game writes are buffered in a small FIFO so the renderer rarely stalls.
- The block converts (x, y) to a linear address and drives registered wren/addr/data to the framebuffer RAM.

Parameters:
WIDTH, 160, screen width in pixels
HEIGHT, 120, screen height in pixels
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
ADDR_W, 15, framebuffer address width
COLOR_W, 3, pixel colour width
FIFO_DEPTH, 4, game write FIFO entries (power of two, >= 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
spl_req  in  1  splash requests and holds the port; stays high for the whole burst
spl_x  in  X_W  splash pixel x
spl_y  in  Y_W  splash pixel y
spl_color  in  COLOR_W  splash pixel colour
spl_last  in  1  current splash pixel is the final one of the burst
spl_gnt  out  1  splash pixel on the inputs is consumed this cycle
game_valid  in  1  game pixel offered
game_x  in  X_W  game pixel x
game_y  in  Y_W  game pixel y
game_color  in  COLOR_W  game pixel colour
game_ready  out  1  FIFO can accept; a push occurs when game_valid && game_ready
busy  out  1  state != IDLE or FIFO non-empty
oob_err  out  1  sticky; an out-of-range coordinate was dropped
vram_wren  out  1  framebuffer write enable (registered)
vram_addr  out  ADDR_W  framebuffer address (registered)
vram_data  out  COLOR_W  framebuffer data (registered)

Behaviour:
- Reset (async, rst=1):
  - State is IDLE and the FIFO is empty (pointers and count 0).
  - vram_wren=0, vram_addr=0, vram_data=0, oob_err=0, spl_gnt=0, busy=0.
  - game_ready=0 while rst is high.
  - Reset mid-burst discards the burst and all FIFO contents. No partial write is emitted after rst deasserts.
- game_ready = !fifo_full. It does not depend on a same-cycle pop, so a full FIFO refuses a push even when popping.
- States: IDLE, SPLASH, GAME.
- IDLE:
  - If spl_req, go to SPLASH.
  - Else if FIFO non-empty, go to GAME.
  - Else stay in IDLE.
  - No grant or pop happens in IDLE; there is one bubble cycle on entry.
- SPLASH:
  - spl_gnt = spl_req. Each granted cycle consumes one splash pixel.
  - When spl_gnt && spl_last, go to GAME if the FIFO is non-empty, else IDLE.
  - If spl_req drops without spl_last, return to IDLE. The burst is abandoned and no error is raised.
  - The FIFO is never popped in SPLASH. Game pushes continue until the FIFO is full.
- GAME:
  - Pop one FIFO entry per cycle.
  - If spl_req is high, go to SPLASH after this cycle's pop; the pop still completes.
  - Else if the FIFO becomes empty this cycle (count==1, no push), go to IDLE.
  - Else stay in GAME.
- A push and a pop in the same cycle leave the count unchanged. A push into an empty FIFO is poppable no earlier than the next cycle.
- Write path, for each consumed pixel (splash grant or FIFO pop):
  - If x < WIDTH and y < HEIGHT: next cycle vram_wren=1, vram_addr = y*WIDTH + x computed at ADDR_W bits, vram_data = colour.
  - Otherwise: vram_wren=0 next cycle and oob_err is set. oob_err clears only on rst.
- Latency from consumption to vram_wren is exactly 1 cycle. vram_wren=0 on every cycle with no consumption. vram_addr/vram_data hold their last value when vram_wren=0.
- Address range: max 119*160+159 = 19199, which fits 15 bits. The multiply must not truncate below ADDR_W.
- FIFO pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- spl_req rising in GAME while the FIFO is full: splash still wins after the current pop. game_ready stays low until a later GAME pop frees an entry.

Test Plan:
- Reset mid-burst: assert rst during the 50th splash pixel -> vram_wren=0 immediately; game_ready=0 while rst is high; after release, state IDLE, busy=0, no writes.
- Full splash fill: spl_req held for 19200 pixels, raster order, last on (159,119) -> entry bubble, then 19200 consecutive vram_wren pulses with addr 0..19199 in order; spl_gnt drops after last; return to IDLE.
- Game single pixel: push (10,5,colour 3) in IDLE -> pop 2 cycles later, vram_wren 1 cycle after the pop with addr 810, data 3; busy then clears.
- Contention: 6 game pushes on back-to-back cycles during a splash burst -> FIFO fills at 4 and game_ready=0; the 5th waits until after spl_last; entries then drain in FIFO order with no gaps; no game write is interleaved inside the burst.
- Preemption: spl_req rises in GAME with 3 entries queued -> exactly one more pop is written, then the splash burst runs, then the remaining 2 drain.
- Out of range: game pixel (160,0) and splash pixel (0,120) -> no vram_wren for either; oob_err=1 and stays 1 until rst.
